matmul_job_scheduler: RTL and testbench

//  Job-level sequencer for the 64x64 matmul core: accepts host run requests, re-arms the core
//  (its done is sticky until reset), pulses start, waits for done.

---
 rtl/matmul_pkg.sv | 20 ++
 rtl/mm_sched_watchdog.sv | 27 ++
 rtl/matmul_job_scheduler.sv | 157 +++++++++++++++
 tb/tb_matmul_job_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and sizing for the matmul job scheduler.
// No logic; 0 latency; no flow control.
package matmul_pkg;

  localparam int MM_OUT_AW  = 12;
  localparam int MM_DATA_W  = 32;
  localparam int N_DIM      = 64;
  // Nominal start-to-done length of one 64x64 job.
  localparam int MM_JOB_CYC = N_DIM * N_DIM + 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_START,
    ST_RUN,
    ST_READY,
    ST_ERR
  } sched_state_e;

endpackage

// File: rtl/mm_sched_watchdog.sv
// RUN-state watchdog: counts RUN cycles, flags the last allowed one (used under MM_SCHED_TIMEOUT_EN).
// timeout is combinational from the count; counter clears whenever not in RUN.
// No backpressure.
module mm_sched_watchdog #(
  parameter int TIMEOUT_CYC = 8192
) (
  input  logic clk,
  input  logic rst,
  input  logic in_run,
  output logic timeout
);

  logic [13:0] cnt_q;
  logic [13:0] cnt_d;

  always_comb begin
    cnt_d = in_run ? cnt_q + 14'd1 : 14'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 14'd0;
    else     cnt_q <= cnt_d;
  end

  assign timeout = in_run && (cnt_q == 14'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/matmul_job_scheduler.sv
// Job sequencer + output-SRAM port owner for the matmul core; watchdog under MM_SCHED_TIMEOUT_EN.
// Status/core controls registered (1 cycle); SRAM port mux and rd_gnt combinational.
// Host reads held off outside READY; run_req pending while busy is serviced on entry to READY.
module matmul_job_scheduler
  import matmul_pkg::*;
#(
  parameter int OUT_AW      = MM_OUT_AW,
  parameter int DATA_W      = MM_DATA_W,
  parameter int CLR_CYC     = 2,
  parameter int TIMEOUT_CYC = 8192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_req,
  output logic              run_ack,
  output logic              busy,
  output logic              result_ready,
  input  logic              rd_req,
  input  logic [OUT_AW-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              core_rst_n,
  output logic              core_start,
  input  logic              core_done,
  input  logic              core_en_out,
  input  logic              core_we_out,
  input  logic [OUT_AW-1:0] core_addr_out,
  output logic              mem_en,
  output logic              mem_we,
  output logic [OUT_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        job_cnt,
  output logic              err
);

  sched_state_e state_q, state_d;
  logic [7:0]   clr_cnt_q, clr_cnt_d;
  logic [7:0]   job_cnt_q, job_cnt_d;
  logic         run_ack_q, run_ack_d;
  logic         core_rst_n_q, core_rst_n_d;
  logic         core_start_q, core_start_d;
  logic         busy_q, busy_d;
  logic         result_ready_q, result_ready_d;
  logic         rd_data_valid_q, rd_data_valid_d;
  logic         err_q, err_d;
  logic         wd_timeout;

`ifdef MM_SCHED_TIMEOUT_EN
  mm_sched_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .in_run  (state_q == ST_RUN),
    .timeout (wd_timeout)
  );
`else
  assign wd_timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    job_cnt_d = job_cnt_q;
    run_ack_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_READY, ST_ERR: begin
        if (run_req) begin
          run_ack_d = 1'b1;
          clr_cnt_d = 8'd0;
          state_d   = ST_CLR;
        end
      end
      ST_CLR: begin
        if (clr_cnt_q == 8'(CLR_CYC - 1)) state_d = ST_START;
        else                              clr_cnt_d = clr_cnt_q + 8'd1;
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        // done beats a coincident watchdog expiry
        if (core_done) begin
          state_d   = ST_READY;
          job_cnt_d = job_cnt_q + 8'd1;
        end else if (wd_timeout) begin
          state_d = ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs are decoded from the next state so they line up with it.
    core_rst_n_d    = (state_d == ST_START) || (state_d == ST_RUN) || (state_d == ST_READY);
    core_start_d    = (state_d == ST_START);
    busy_d          = (state_d == ST_CLR) || (state_d == ST_START) || (state_d == ST_RUN);
    result_ready_d  = (state_d == ST_READY);
    err_d           = (state_d == ST_ERR);
    rd_data_valid_d = rd_gnt;
  end

  always_comb begin
    rd_gnt   = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    case (state_q)
      ST_CLR, ST_START, ST_RUN: begin
        mem_en   = core_en_out;
        mem_we   = core_we_out;
        mem_addr = core_addr_out;
      end
      ST_READY: begin
        rd_gnt   = rd_req & ~run_req;
        mem_en   = rd_gnt;
        mem_addr = rd_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      clr_cnt_q       <= 8'd0;
      job_cnt_q       <= 8'd0;
      run_ack_q       <= 1'b0;
      core_rst_n_q    <= 1'b0;
      core_start_q    <= 1'b0;
      busy_q          <= 1'b0;
      result_ready_q  <= 1'b0;
      rd_data_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      clr_cnt_q       <= clr_cnt_d;
      job_cnt_q       <= job_cnt_d;
      run_ack_q       <= run_ack_d;
      core_rst_n_q    <= core_rst_n_d;
      core_start_q    <= core_start_d;
      busy_q          <= busy_d;
      result_ready_q  <= result_ready_d;
      rd_data_valid_q <= rd_data_valid_d;
      err_q           <= err_d;
    end
  end

  assign run_ack       = run_ack_q;
  assign busy          = busy_q;
  assign result_ready  = result_ready_q;
  assign rd_data_valid = rd_data_valid_q;
  assign rd_data       = mem_rdata;
  assign core_rst_n    = core_rst_n_q;
  assign core_start    = core_start_q;
  assign job_cnt       = job_cnt_q;
  assign err           = err_q;

endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Directed + randomized bench for matmul_job_scheduler with a timeline-based reference model.
module tb_matmul_job_scheduler;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int CLRC = 2;
  localparam int TO   = 16;
  localparam int JOB  = 4106;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run_req = 1'b0;
  logic          run_ack, busy, result_ready;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_gnt, rd_data_valid;
  logic [DW-1:0] rd_data;
  logic          core_rst_n, core_start;
  logic          core_done = 1'b0;
  logic          core_en_out = 1'b0;
  logic          core_we_out = 1'b0;
  logic [AW-1:0] core_addr_out = '0;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [7:0]    job_cnt;
  logic          err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t_start = 0;
  int done_delay = JOB;
  int core_cyc = 0;
  bit core_run = 1'b0;
  bit last_exp_gnt = 1'b0;
  int jobs_done = 0;

  matmul_job_scheduler #(
    .OUT_AW (AW), .DATA_W (DW), .CLR_CYC (CLRC), .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk), .rst (rst),
    .run_req (run_req), .run_ack (run_ack), .busy (busy), .result_ready (result_ready),
    .rd_req (rd_req), .rd_addr (rd_addr), .rd_gnt (rd_gnt),
    .rd_data_valid (rd_data_valid), .rd_data (rd_data),
    .core_rst_n (core_rst_n), .core_start (core_start), .core_done (core_done),
    .core_en_out (core_en_out), .core_we_out (core_we_out), .core_addr_out (core_addr_out),
    .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr), .mem_rdata (mem_rdata),
    .job_cnt (job_cnt), .err (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: done rises done_delay cycles after it sees start, sticky until core reset.
  always @(posedge clk) begin
    if (!core_rst_n) begin
      core_done <= 1'b0;
      core_run  <= 1'b0;
      core_cyc  <= 0;
    end else if (core_start) begin
      core_run <= 1'b1;
      core_cyc <= 1;
    end else if (core_run) begin
      core_cyc <= core_cyc + 1;
      if (core_cyc == done_delay) core_done <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Port-ownership rules: core owns the SRAM while busy, host reads only in READY.
  task automatic chk_mux(input bit core_owns, input bit in_ready);
    bit e_gnt;
    e_gnt = in_ready && rd_req && !run_req;
    chk("rd_gnt", rd_gnt, e_gnt);
    chk("mem_en", mem_en, core_owns ? core_en_out : e_gnt);
    chk("mem_we", mem_we, core_owns ? core_we_out : 1'b0);
    if (core_owns || e_gnt)
      chk("mem_addr", mem_addr, core_owns ? core_addr_out : rd_addr);
    last_exp_gnt = e_gnt;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive_rand();
    core_en_out   = 1'($urandom);
    core_we_out   = 1'($urandom);
    core_addr_out = AW'($urandom);
    rd_req        = 1'($urandom);
    rd_addr       = AW'($urandom);
    mem_rdata     = $urandom;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_core_rst_n"}, core_rst_n, 1'b0);
    chk({tag, "_core_start"}, core_start, 1'b0);
    chk({tag, "_run_ack"}, run_ack, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_result_ready"}, result_ready, 1'b0);
    chk({tag, "_rd_data_valid"}, rd_data_valid, 1'b0);
    chk({tag, "_job_cnt"}, job_cnt, 8'd0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_rd_gnt"}, rd_gnt, 1'b0);
    chk({tag, "_mem_en"}, mem_en, 1'b0);
  endtask

  // Request a job and follow it through CLR and START into the first RUN cycle.
  task automatic start_job(input bit from_ready);
    next();
    run_req = 1'b1;
    rd_req  = 1'b1;
    rd_addr = AW'($urandom);
    settle();
    chk("pre_ack", run_ack, 1'b0);
    chk_mux(1'b0, from_ready);
    for (int i = 1; i <= CLRC + 2; i++) begin
      next();
      if (i == 1) run_req = 1'b0;
      drive_rand();
      settle();
      chk("run_ack", run_ack, i == 1);
      chk("core_rst_n", core_rst_n, i > CLRC);
      chk("core_start", core_start, i == CLRC + 1);
      chk("busy", busy, 1'b1);
      chk("result_ready", result_ready, 1'b0);
      chk_mux(1'b1, 1'b0);
      if (i == CLRC + 1) t_start = cyc;
    end
  endtask

  // RUN until the model's done point (start seen, D cycles, then one cycle to register).
  task automatic run_to_ready();
    bit er;
    for (int k = 0; k < done_delay + 10; k++) begin
      next();
      drive_rand();
      settle();
      er = (cyc - t_start) >= done_delay + 2;
      chk("busy_run", busy, !er);
      chk("ready_run", result_ready, er);
      chk("job_cnt_run", job_cnt, er ? 8'(jobs_done + 1) : 8'(jobs_done));
      chk("core_start_run", core_start, 1'b0);
      chk("err_run", err, 1'b0);
      chk_mux(!er, er);
      if (er) break;
    end
    jobs_done++;
  endtask

  task automatic host_reads(input int n);
    for (int i = 0; i < n; i++) begin
      next();
      rd_req    = (i == 0) ? 1'b1 : 1'($urandom);
      rd_addr   = (i == 0) ? AW'(12'hFFF) : AW'($urandom);
      mem_rdata = $urandom;
      settle();
      chk("rd_data_valid", rd_data_valid, last_exp_gnt);
      chk("rd_data", rd_data, mem_rdata);
      chk("ready_hold", result_ready, 1'b1);
      chk_mux(1'b0, 1'b1);
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    rd_req = 1'b1;
    settle();
    chk_reset_vals("reset");
    next();
    rst = 1'b0;
    rd_req = 1'b0;
    settle();
    chk_reset_vals("post_reset");

    // Job 1: nominal length.
    done_delay = JOB;
    start_job(1'b0);
    run_to_ready();
    host_reads(10);

    // Job 2: requested together with a read, short random length.
    done_delay = int'($urandom_range(5, 40));
    start_job(1'b1);
    run_to_ready();
    chk("job_cnt_2", job_cnt, 8'd2);
    host_reads(6);

`ifdef MM_SCHED_TIMEOUT_EN
    // Core never finishes: watchdog expires after TO RUN cycles.
    done_delay = 1000000;
    start_job(1'b1);
    for (int k = 0; k < TO + 10; k++) begin
      bit ee;
      next();
      drive_rand();
      settle();
      ee = (cyc - t_start) >= TO + 1;
      chk("err_wd", err, ee);
      chk("busy_wd", busy, !ee);
      chk("core_rst_n_wd", core_rst_n, !ee);
      chk("result_ready_wd", result_ready, 1'b0);
      chk_mux(!ee, 1'b0);
      if (ee) break;
    end
    chk("job_cnt_wd", job_cnt, 8'd2);
    done_delay = int'($urandom_range(5, 20));
    start_job(1'b0);
    chk("err_cleared", err, 1'b0);
    run_to_ready();
    chk("job_cnt_after_err", job_cnt, 8'(jobs_done));
`endif

    // Reset asserted between edges in the middle of RUN.
    done_delay = 1000000;
    start_job(1'b1);
    repeat (5) next();
    #2 rst = 1'b1;
    rd_req = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    next();
    rst = 1'b0;
    rd_req = 1'b0;
    settle();
    chk_reset_vals("after_mid_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
